// File: rtl/avl_ddr3_arbiter.sv
// avl_ddr3_arbiter: round-robin two-port Avalon-MM arbiter with write-burst lock and in-order read-return routing
module avl_ddr3_arbiter #(
  parameter int TAG_DEPTH = 8,
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_init_done,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [2:0]          m0_size,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rdata_valid,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [2:0]          m1_size,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rdata_valid,
  input  logic                avl_ready,
  input  logic [DATA_W-1:0]   avl_rdata,
  input  logic                avl_rdata_valid,
  output logic                avl_read_req,
  output logic                avl_write_req,
  output logic                avl_burstbegin,
  output logic [ADDR_W-1:0]   avl_addr,
  output logic [2:0]          avl_size,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W/8-1:0] avl_be
);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic {IDLE, WBURST} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d, owner_q, owner_d, err_orphan_q;
  logic [2:0]    left_q, left_d, wsize_q, wsize_d, rbeat_q, rbeat_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          tag_port_q [TAG_DEPTH];
  logic [2:0]    tag_size_q [TAG_DEPTH];
  logic          full, el0, el1, sel, gnt, wr, acc, push, pop, rv, hport;
  logic [2:0]    s0, s1, ssel, hsize;
  // grant selection, command mux and read-return routing
  always_comb begin
    s0 = m0_size == 3'd0 ? 3'd1 : m0_size;
    s1 = m1_size == 3'd0 ? 3'd1 : m1_size;
    full = count_q == (PW+1)'(TAG_DEPTH);
    el0 = i_init_done & (m0_write | (m0_read & !full));
    el1 = i_init_done & (m1_write | (m1_read & !full));
    sel = state_q == WBURST ? owner_q : (el0 & el1 ? !last_q : !el0);
    gnt = state_q == WBURST ? i_init_done & (owner_q ? m1_write : m0_write) : (el0 | el1);
    wr = sel ? m1_write : m0_write;
    ssel = sel ? s1 : s0;
    acc = gnt & avl_ready;
    push = acc & !wr;
    avl_write_req = gnt & wr & i_rst_n;
    avl_read_req = gnt & !wr & i_rst_n;
    avl_burstbegin = gnt & (state_q == IDLE) & i_rst_n;
    avl_addr = sel ? m1_addr : m0_addr;
    avl_size = state_q == WBURST ? wsize_q : ssel;
    avl_wdata = sel ? m1_wdata : m0_wdata;
    avl_be = sel ? m1_be : m0_be;
    m0_waitrequest = !(acc & !sel & i_rst_n);
    m1_waitrequest = !(acc & sel & i_rst_n);
    hport = tag_port_q[rptr_q];
    hsize = tag_size_q[rptr_q];
    rv = avl_rdata_valid & (count_q != '0);
    pop = rv & (rbeat_q == hsize - 3'd1);
    rbeat_d = !rv ? rbeat_q : (pop ? 3'd0 : rbeat_q + 3'd1);
    m0_rdata = avl_rdata;
    m1_rdata = avl_rdata;
    m0_rdata_valid = rv & !hport & i_rst_n;
    m1_rdata_valid = rv & hport & i_rst_n;
  end
  // burst-lock FSM next state
  always_comb begin
    state_d = state_q;
    left_d = left_q;
    owner_d = owner_q;
    wsize_d = wsize_q;
    last_d = acc ? sel : last_q;
    if (acc & wr & (state_q == IDLE) & (ssel > 3'd1)) begin
      state_d = WBURST;
      left_d = ssel - 3'd1;
      owner_d = sel;
      wsize_d = ssel;
    end else if (acc & (state_q == WBURST)) begin
      left_d = left_q - 3'd1;
      state_d = left_q == 3'd1 ? IDLE : WBURST;
    end
  end
  // control state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      left_q <= 3'd0;
      wsize_q <= 3'd1;
      rbeat_q <= 3'd0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      left_q <= left_d;
      wsize_q <= wsize_d;
      rbeat_q <= rbeat_d;
      wptr_q <= push ? wptr_q + PW'(1) : wptr_q;
      rptr_q <= pop ? rptr_q + PW'(1) : rptr_q;
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      err_orphan_q <= err_orphan_q | (avl_rdata_valid & (count_q == '0));
    end
  end
  // tag FIFO storage: {port, beat count} per accepted read
  always_ff @(posedge i_clk) begin
    if (push) begin
      tag_port_q[wptr_q] <= sel;
      tag_size_q[wptr_q] <= ssel;
    end
  end
endmodule

// File: tb/tb_avl_ddr3_arbiter.sv
// tb_avl_ddr3_arbiter: randomized requesters and controller checked against a queue-based reference model
module tb_avl_ddr3_arbiter;
  localparam int TD = 8, AW = 26, DW = 64;
  logic clk = 0, rst_n = 0, init_done = 0;
  logic m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, avl_addr;
  logic [2:0] m0_size = '0, m1_size = '0, avl_size;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, avl_wdata, avl_rdata = '0, m0_rdata, m1_rdata;
  logic [DW/8-1:0] m0_be = '0, m1_be = '0, avl_be;
  logic m0_waitrequest, m1_waitrequest, m0_rdata_valid, m1_rdata_valid;
  logic avl_ready = 0, avl_rdata_valid = 0, avl_read_req, avl_write_req, avl_burstbegin;
  int checks = 0, errors = 0;
  int m_last, m_wb, m_owner, m_left, m_wsize, m_rbeat;
  int tq_port[$], tq_size[$];
  int g_act[2], g_wr[2], g_both[2], g_size[2], g_rem[2], g_gap[2], g_stall[2];
  logic [DW-1:0] g_data[2];
  logic [31:0] g_addr[2];
  logic [7:0] g_be[2];
  int no_gap = 0;

  avl_ddr3_arbiter #(.TAG_DEPTH(TD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_waitrequest(m0_waitrequest),
    .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_waitrequest(m1_waitrequest),
    .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .avl_ready(avl_ready), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_burstbegin(avl_burstbegin),
    .avl_addr(avl_addr), .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_be(avl_be));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int norm(int s);
    return s == 0 ? 1 : s;
  endfunction

  task automatic clear_all();
    m_last = 1; m_wb = 0; m_owner = 0; m_left = 0; m_wsize = 1; m_rbeat = 0;
    tq_port.delete(); tq_size.delete();
    for (int p = 0; p < 2; p++) begin
      g_act[p] = 0; g_gap[p] = 0; g_stall[p] = 0; g_both[p] = 0;
    end
  endtask

  task automatic drive();
    m0_read = g_act[0] && (!g_wr[0] || (g_both[0] && !g_gap[0]));
    m0_write = g_act[0] && g_wr[0] && !g_gap[0];
    m0_addr = g_addr[0][AW-1:0]; m0_size = 3'(g_size[0]); m0_wdata = g_data[0]; m0_be = g_be[0];
    m1_read = g_act[1] && (!g_wr[1] || (g_both[1] && !g_gap[1]));
    m1_write = g_act[1] && g_wr[1] && !g_gap[1];
    m1_addr = g_addr[1][AW-1:0]; m1_size = 3'(g_size[1]); m1_wdata = g_data[1]; m1_be = g_be[1];
  endtask

  task automatic step(input int rv_pct, input int rdy_pct, input int init_pct);
    int r[2], w[2], el[2], gv, gp, acc, hv, sz;
    logic [AW-1:0] ea;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!g_act[p] && $urandom % 2 == 0) begin
        g_act[p] = 1; g_wr[p] = $urandom % 2; g_both[p] = ($urandom % 8 == 0);
        g_size[p] = $urandom % 8; g_rem[p] = norm(g_size[p]); g_addr[p] = $urandom;
        g_data[p] = {$urandom, $urandom}; g_be[p] = 8'($urandom); g_gap[p] = 0;
      end else if (g_act[p] && g_wr[p] && !g_stall[p] && g_rem[p] != norm(g_size[p]))
        g_gap[p] = !no_gap && ($urandom % 4 == 0);
    end
    drive();
    avl_ready = ($urandom % 100) < rdy_pct;
    init_done = ($urandom % 100) < init_pct;
    avl_rdata = {$urandom, $urandom};
    avl_rdata_valid = tq_port.size() > 0 ? ($urandom % 100) < rv_pct : ($urandom % 20 == 0);
    #1;
    r[0] = m0_read; r[1] = m1_read; w[0] = m0_write; w[1] = m1_write;
    for (int p = 0; p < 2; p++) el[p] = init_done && (w[p] || (r[p] && tq_port.size() < TD));
    if (m_wb) begin
      gp = m_owner; gv = init_done && w[gp];
    end else begin
      gv = el[0] || el[1];
      gp = (el[0] && el[1]) ? 1 - m_last : (el[0] ? 0 : 1);
    end
    acc = gv && avl_ready;
    check("write_req", avl_write_req, gv && w[gp]);
    check("read_req", avl_read_req, gv && !w[gp]);
    check("burstbegin", avl_burstbegin, gv && !m_wb);
    check("wait0", m0_waitrequest, !(acc && gp == 0));
    check("wait1", m1_waitrequest, !(acc && gp == 1));
    if (gv) begin
      ea = gp ? m1_addr : m0_addr;
      sz = m_wb ? m_wsize : norm(gp ? m1_size : m0_size);
      check("addr", avl_addr, ea);
      check("size", avl_size, sz);
      if (w[gp]) begin
        check("wdata", avl_wdata, gp ? m1_wdata : m0_wdata);
        check("be", avl_be, gp ? m1_be : m0_be);
      end
    end
    hv = tq_port.size() > 0;
    check("rvalid0", m0_rdata_valid, avl_rdata_valid && hv && tq_port[0] == 0);
    check("rvalid1", m1_rdata_valid, avl_rdata_valid && hv && tq_port[0] == 1);
    if (m0_rdata_valid) check("rdata0", m0_rdata, avl_rdata);
    if (m1_rdata_valid) check("rdata1", m1_rdata, avl_rdata);
    @(posedge clk);
    if (acc) begin
      m_last = gp;
      if (m_wb) begin
        m_left--;
        if (m_left == 0) m_wb = 0;
      end else if (w[gp]) begin
        if (norm(g_size[gp]) > 1) begin
          m_wb = 1; m_owner = gp; m_left = norm(g_size[gp]) - 1; m_wsize = norm(g_size[gp]);
        end
      end else begin
        tq_port.push_back(gp); tq_size.push_back(norm(g_size[gp]));
      end
      if (w[gp]) begin
        g_rem[gp]--;
        g_data[gp] = {$urandom, $urandom}; g_be[gp] = 8'($urandom);
        if (g_rem[gp] == 0) g_act[gp] = 0;
      end else g_act[gp] = 0;
    end
    for (int p = 0; p < 2; p++) g_stall[p] = (r[p] || w[p]) && !(acc && gp == p);
    if (avl_rdata_valid && hv) begin
      m_rbeat++;
      if (m_rbeat == tq_size[0]) begin
        void'(tq_port.pop_front()); void'(tq_size.pop_front()); m_rbeat = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rreq"}, avl_read_req, 0);
    check({tag, "_wreq"}, avl_write_req, 0);
    check({tag, "_bb"}, avl_burstbegin, 0);
    check({tag, "_wait0"}, m0_waitrequest, 1);
    check({tag, "_wait1"}, m1_waitrequest, 1);
    check({tag, "_rv0"}, m0_rdata_valid, 0);
    check({tag, "_rv1"}, m1_rdata_valid, 0);
  endtask

  initial begin
    int n;
    clear_all();
    m0_read = 1; m1_write = 1; init_done = 1; avl_ready = 1; avl_rdata_valid = 1;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    drive(); avl_rdata_valid = 0; rst_n = 1;
    repeat (300) step(30, 80, 100);
    repeat (300) step(4, 90, 100);
    repeat (300) step(60, 50, 90);
    no_gap = 1;
    n = 0;
    while (!m_wb && n < 400) begin
      step(30, 90, 100);
      n++;
    end
    check("reach_wburst", m_wb, 1);
    @(negedge clk);
    avl_rdata_valid = 1;
    #2 rst_n = 0;
    #1 check_reset_outputs("async_reset");
    clear_all();
    drive(); avl_rdata_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    no_gap = 0;
    repeat (300) step(40, 80, 95);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
